// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// The sequencer connects through the master modport; its environment uses slave.
interface fetch_sequencer_if #(
  parameter int PC_W = 32
);
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [PC_W-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [PC_W-1:0] if_pc;
  logic [PC_W-1:0] if_instr;
  logic            misalign_err;
  logic [31:0]     fetch_count;

  modport master (
    input  redirect_valid, redirect_pc, imem_ack, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err, fetch_count
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ack, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one outstanding imem request
// at a time, presents fetched words to decode and honours MEM-stage redirects.
module fetch_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.master bus
);
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]      state_r, state_nxt_s;
  logic [PC_W-1:0] pc_r, pc_nxt_s;
  logic [PC_W-1:0] addr_r, addr_nxt_s;
  logic            req_r, req_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic [PC_W-1:0] if_pc_r, if_pc_nxt_s;
  logic [PC_W-1:0] if_instr_r, if_instr_nxt_s;
  logic            misalign_r, misalign_nxt_s;
  logic [31:0]     count_r, count_nxt_s;
  logic [PC_W-1:0] target_s;

  assign target_s = {bus.redirect_pc[PC_W-1:2], 2'b00};

  // Next-state and next-output computation for every registered signal
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    valid_nxt_s    = valid_r;
    if_pc_nxt_s    = if_pc_r;
    if_instr_nxt_s = if_instr_r;
    count_nxt_s    = count_r;
    addr_nxt_s     = addr_r;
    misalign_nxt_s = misalign_r |
                     (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00));
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_FETCH;
        if (bus.redirect_valid) pc_nxt_s = target_s;
        else                    pc_nxt_s = pc_r;
      end
      ST_FETCH: begin
        if (bus.redirect_valid) begin
          pc_nxt_s = target_s;
          // Redirect with simultaneous ack retires the request right here
          if (bus.imem_ack) state_nxt_s = ST_FETCH;
          else              state_nxt_s = ST_DRAIN;
        end else if (bus.imem_ack) begin
          if_instr_nxt_s = bus.imem_rdata;
          if_pc_nxt_s    = pc_r;
          pc_nxt_s       = pc_r + {{(PC_W-3){1'b0}}, 3'b100};
          valid_nxt_s    = 1'b1;
          state_nxt_s    = ST_OUT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (bus.redirect_valid) pc_nxt_s = target_s;
        else                    pc_nxt_s = pc_r;
        if (bus.imem_ack) state_nxt_s = ST_FETCH;
        else              state_nxt_s = ST_DRAIN;
      end
      ST_OUT: begin
        if (bus.redirect_valid || bus.if_ready) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_FETCH;
          if (bus.redirect_valid) pc_nxt_s = target_s;
          else                    pc_nxt_s = pc_r;
          if (bus.if_ready) count_nxt_s = count_r + 32'd1;
          else              count_nxt_s = count_r;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
        valid_nxt_s = 1'b0;
      end
    endcase
    req_nxt_s = (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_DRAIN);
    // DRAIN keeps presenting the address of the request still in flight
    if (state_nxt_s == ST_FETCH)     addr_nxt_s = pc_nxt_s;
    else if (state_r == ST_FETCH)    addr_nxt_s = pc_r;
    else                             addr_nxt_s = addr_r;
  end

  // State, PC and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_PC;
      addr_r     <= RESET_PC;
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
      if_pc_r    <= {PC_W{1'b0}};
      if_instr_r <= {PC_W{1'b0}};
      misalign_r <= 1'b0;
      count_r    <= 32'd0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      addr_r     <= addr_nxt_s;
      req_r      <= req_nxt_s;
      valid_r    <= valid_nxt_s;
      if_pc_r    <= if_pc_nxt_s;
      if_instr_r <= if_instr_nxt_s;
      misalign_r <= misalign_nxt_s;
      count_r    <= count_nxt_s;
    end
  end

  assign bus.imem_req     = req_r;
  assign bus.imem_addr    = addr_r;
  assign bus.if_valid     = valid_r;
  assign bus.if_pc        = if_pc_r;
  assign bus.if_instr     = if_instr_r;
  assign bus.misalign_err = misalign_r;
  assign bus.fetch_count  = count_r;
endmodule
